// File: rtl/can_pkg.sv
// Shared states, field widths and frame header layout for the team CAN serial link.
// Pure declarations: no latency, no backpressure.
package can_pkg;

  localparam int ID_W   = 1;
  localparam int DLC_W  = 4;
  localparam int DATA_W = 16;
  localparam int CRC_W  = 15;
  localparam int EOF_W  = 7;
  localparam int IFS_W  = 3;
  localparam int ARB_W  = 2;
  localparam int CTRL_W = 6;
  localparam int HDR_W  = ARB_W + CTRL_W + DATA_W;
  localparam int CNT_W  = 5;

  localparam logic [CRC_W-1:0] CRC15_POLY = 15'h4599;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SOF,
    S_ARB,
    S_CTRL,
    S_DATA,
    S_CRC,
    S_CRC_DEL,
    S_ACK,
    S_ACK_DEL,
    S_EOF,
    S_IFS
  } state_t;

  // Bit order matches the wire order, so the header shifts in MSB first.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              rtr;
    logic              ide;
    logic              r0;
    logic [DLC_W-1:0]  dlc;
    logic [DATA_W-1:0] data;
  } hdr_t;

  function automatic logic [CNT_W-1:0] field_last(input state_t s);
    case (s)
      S_ARB:   return CNT_W'(ARB_W - 1);
      S_CTRL:  return CNT_W'(CTRL_W - 1);
      S_DATA:  return CNT_W'(DATA_W - 1);
      S_CRC:   return CNT_W'(CRC_W - 1);
      S_EOF:   return CNT_W'(EOF_W - 1);
      S_IFS:   return CNT_W'(IFS_W - 1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/can_crc15_serial.sv
// Serial CRC-15, one bit per bit_en; result visible the cycle after the last bit.
// No backpressure: the caller paces bits; clear has priority over bit_en.
module can_crc15_serial
  import can_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC15_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = bit_in ^ crc[CRC_W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (bit_en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/can_frame_rx.sv
// CAN frame receiver: sync, bit timing, field FSM, CRC check, ACK drive, decoded outputs.
// Latency: rx_valid one cycle after the last EOF sample point; bus-timed, no backpressure.
module can_frame_rx
  import can_pkg::*;
#(
  parameter int               BIT_TICKS = 16,
  parameter logic [CRC_W-1:0] CRC_POLY  = CRC15_POLY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              can_rx,
  output logic              can_tx,
  output logic              rx_valid,
  output logic              rx_id,
  output logic              rx_rtr,
  output logic              rx_ide,
  output logic [DLC_W-1:0]  rx_dlc,
  output logic [DATA_W-1:0] rx_data,
  output logic              crc_err,
  output logic              form_err
);

  localparam int            TW       = $clog2(BIT_TICKS);
  localparam logic [TW-1:0] SAMPLE_T = TW'(BIT_TICKS / 2 - 1);
  localparam logic [TW-1:0] LAST_T   = TW'(BIT_TICKS - 1);

  logic             rx_s1, rx_s2, rx_prev;
  logic [TW-1:0]    tick_cnt;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  hdr_t             hdr_sr;
  logic [CRC_W-1:0] crc_rx, crc_calc;
  logic             err_flag, err_nxt;
  logic             ack_drv, ack_nxt;
  logic             fall, sample, last_bit, crc_ok;
  logic             frame_start, valid_nxt, crc_err_nxt, form_err_nxt;

  assign fall     = rx_prev & ~rx_s2;
  assign sample   = (state != S_IDLE) && (tick_cnt == SAMPLE_T);
  assign last_bit = (bit_cnt == '0);
  assign crc_ok   = (crc_calc == crc_rx);
  assign can_tx   = ~ack_drv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= can_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Held at zero while idle, so the SOF edge acts as a hard sync.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (state == S_IDLE) begin
      tick_cnt <= '0;
    end else if (tick_cnt == LAST_T) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      err_flag <= 1'b0;
      ack_drv  <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      err_flag <= err_nxt;
      ack_drv  <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    err_nxt      = err_flag;
    ack_nxt      = ack_drv;
    frame_start  = 1'b0;
    valid_nxt    = 1'b0;
    crc_err_nxt  = 1'b0;
    form_err_nxt = 1'b0;
    if (state == S_IDLE) begin
      if (fall) begin
        state_nxt   = S_SOF;
        bit_cnt_nxt = '0;
        frame_start = 1'b1;
        err_nxt     = 1'b0;
      end
    end else if (sample) begin
      bit_cnt_nxt = bit_cnt - CNT_W'(1);
      case (state)
        S_SOF:  state_nxt = rx_s2 ? S_IDLE : S_ARB;
        S_ARB:  if (last_bit) state_nxt = S_CTRL;
        S_CTRL: if (last_bit) state_nxt = S_DATA;
        S_DATA: if (last_bit) state_nxt = S_CRC;
        S_CRC:  if (last_bit) state_nxt = S_CRC_DEL;
        S_CRC_DEL: begin
          if (!crc_ok) begin
            crc_err_nxt = 1'b1;
            err_nxt     = 1'b1;
          end
          if (!rx_s2) begin
            form_err_nxt = 1'b1;
            state_nxt    = S_IDLE;
          end else begin
            ack_nxt   = crc_ok;
            state_nxt = S_ACK;
          end
        end
        S_ACK: begin
          ack_nxt   = 1'b0;
          state_nxt = S_ACK_DEL;
        end
        S_ACK_DEL: begin
          if (!rx_s2) begin
            form_err_nxt = 1'b1;
            state_nxt    = S_IDLE;
          end else begin
            state_nxt = S_EOF;
          end
        end
        S_EOF: begin
          if (!rx_s2) begin
            form_err_nxt = 1'b1;
            state_nxt    = S_IDLE;
          end else if (last_bit) begin
            valid_nxt = ~err_flag;
            state_nxt = S_IFS;
          end
        end
        S_IFS:   if (last_bit) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
      if (state_nxt != state) bit_cnt_nxt = field_last(state_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_sr <= '0;
      crc_rx <= '0;
    end else if (sample) begin
      if (state == S_ARB || state == S_CTRL || state == S_DATA) begin
        hdr_sr <= {hdr_sr[HDR_W-2:0], rx_s2};
      end
      if (state == S_CRC) begin
        crc_rx <= {crc_rx[CRC_W-2:0], rx_s2};
      end
    end
  end

  can_crc15_serial #(
    .POLY(CRC_POLY)
  ) u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (frame_start),
    .bit_en(sample && state == S_DATA),
    .bit_in(rx_s2),
    .crc   (crc_calc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid <= 1'b0;
      crc_err  <= 1'b0;
      form_err <= 1'b0;
      rx_id    <= 1'b0;
      rx_rtr   <= 1'b0;
      rx_ide   <= 1'b0;
      rx_dlc   <= '0;
      rx_data  <= '0;
    end else begin
      rx_valid <= valid_nxt;
      crc_err  <= crc_err_nxt;
      form_err <= form_err_nxt;
      if (valid_nxt) begin
        rx_id   <= hdr_sr.id;
        rx_rtr  <= hdr_sr.rtr;
        rx_ide  <= hdr_sr.ide;
        rx_dlc  <= hdr_sr.dlc;
        rx_data <= hdr_sr.data;
      end
    end
  end

endmodule

// File: tb/tb_can_frame_rx.sv
// Bench for can_frame_rx: two instances (16 and 4 ticks per bit) checked against a frame-level scoreboard.
module tb_can_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        can_rx   [2];
  logic        can_tx   [2];
  logic        rx_valid [2];
  logic        rx_id    [2];
  logic        rx_rtr   [2];
  logic        rx_ide   [2];
  logic [3:0]  rx_dlc   [2];
  logic [15:0] rx_data  [2];
  logic        crc_err  [2];
  logic        form_err [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ack_lo [2];
  int ack_hi [2];
  int ack_cnt[2];

  // kind = {rx_valid, crc_err, form_err}
  typedef struct {
    logic [2:0]  kind;
    int          cyc;
    logic        id;
    logic        rtr;
    logic        ide;
    logic [3:0]  dlc;
    logic [15:0] data;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  can_frame_rx #(.BIT_TICKS(16)) dut (
    .clk(clk), .rst(rst), .can_rx(can_rx[0]), .can_tx(can_tx[0]), .rx_valid(rx_valid[0]),
    .rx_id(rx_id[0]), .rx_rtr(rx_rtr[0]), .rx_ide(rx_ide[0]), .rx_dlc(rx_dlc[0]),
    .rx_data(rx_data[0]), .crc_err(crc_err[0]), .form_err(form_err[0])
  );

  can_frame_rx #(.BIT_TICKS(4)) dut4 (
    .clk(clk), .rst(rst), .can_rx(can_rx[1]), .can_tx(can_tx[1]), .rx_valid(rx_valid[1]),
    .rx_id(rx_id[1]), .rx_rtr(rx_rtr[1]), .rx_ide(rx_ide[1]), .rx_dlc(rx_dlc[1]),
    .rx_data(rx_data[1]), .crc_err(crc_err[1]), .form_err(form_err[1])
  );

  function automatic int bt(input int d);
    return (d == 0) ? 16 : 4;
  endfunction

  // Cycle on which a register update caused by the sample of bit n is visible.
  function automatic int sp(input int d, input int t0, input int n);
    return t0 + 3 + bt(d) / 2 + n * bt(d);
  endfunction

  function automatic logic [14:0] crc15(input logic [15:0] v);
    logic [14:0] c;
    logic        nb;
    c = '0;
    for (int i = 15; i >= 0; i--) begin
      nb = v[i] ^ c[14];
      c  = {c[13:0], 1'b0};
      if (nb) c = c ^ 15'h4599;
    end
    return c;
  endfunction

  function automatic logic [52:0] mk_frame(input logic id, input logic rtr, input logic ide,
                                           input logic [3:0] dlc, input logic [15:0] data,
                                           input logic [14:0] crc, input logic ack_del,
                                           input logic [2:0] ifs);
    return {1'b0, id, rtr, ide, 1'b0, dlc, data, crc, 1'b1, 1'b1, ack_del, 7'h7f, ifs};
  endfunction

  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] k;
    for (int d = 0; d < 2; d++) begin
      if (can_tx[d] === 1'b0) begin
        total++;
        ack_cnt[d]++;
        if (cyc < ack_lo[d] || cyc > ack_hi[d]) begin
          bad++;
          $display("FAIL ack_window dut%0d: can_tx low at cycle %0d, allowed %0d..%0d",
                   d, cyc, ack_lo[d], ack_hi[d]);
        end
      end
      if (rx_valid[d] === 1'b1 || crc_err[d] === 1'b1 || form_err[d] === 1'b1) begin
        k = {rx_valid[d], crc_err[d], form_err[d]};
        total++;
        if ((d == 0 ? sb0.size() : sb1.size()) == 0) begin
          bad++;
          $display("FAIL unexpected_event dut%0d: kind %b at cycle %0d, expected none", d, k, cyc);
        end else begin
          e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
          if (k !== e.kind || cyc != e.cyc) begin
            bad++;
            $display("FAIL event dut%0d: kind %b at cycle %0d, expected kind %b at cycle %0d",
                     d, k, cyc, e.kind, e.cyc);
          end else if (e.kind[2]) begin
            total++;
            if ({rx_id[d], rx_rtr[d], rx_ide[d], rx_dlc[d], rx_data[d]} !==
                {e.id, e.rtr, e.ide, e.dlc, e.data}) begin
              bad++;
              $display("FAIL fields dut%0d: got id=%b rtr=%b ide=%b dlc=%h data=%h, expected %b %b %b %h %h",
                       d, rx_id[d], rx_rtr[d], rx_ide[d], rx_dlc[d], rx_data[d],
                       e.id, e.rtr, e.ide, e.dlc, e.data);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  // Frame-level model: predicts pulses, their cycles, and the ACK window.
  task automatic expect_frame(input int d, input logic [52:0] f, input int t0, output int low);
    exp_t e;
    logic ok;
    logic done;
    ok         = (crc15(f[43:28]) == f[27:13]);
    low        = 0;
    ack_lo[d]  = -1;
    ack_hi[d]  = -1;
    ack_cnt[d] = 0;
    e.id   = f[51];
    e.rtr  = f[50];
    e.ide  = f[49];
    e.dlc  = f[47:44];
    e.data = f[43:28];
    if (!ok || !f[12]) begin
      e.kind = {1'b0, !ok, !f[12]};
      e.cyc  = sp(d, t0, 40);
      push_exp(d, e);
    end
    if (f[12]) begin
      if (ok) begin
        ack_lo[d] = sp(d, t0, 40);
        ack_hi[d] = sp(d, t0, 41) - 1;
        low       = bt(d);
      end
      done = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!done && !f[10-k]) begin
          e.kind = 3'b001;
          e.cyc  = sp(d, t0, 42 + k);
          push_exp(d, e);
          done = 1'b1;
        end
      end
      if (!done && ok) begin
        e.kind = 3'b100;
        e.cyc  = sp(d, t0, 49);
        push_exp(d, e);
      end
    end
  endtask

  task automatic drive_bits(input int d, input logic [52:0] f, input int nbits);
    for (int n = 0; n < nbits; n++) begin
      can_rx[d] = f[52-n];
      repeat (bt(d)) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int d, input logic [52:0] f, input string name);
    int low;
    @(posedge clk);
    #1;
    expect_frame(d, f, cyc, low);
    drive_bits(d, f, 53);
    can_rx[d] = 1'b1;
    total++;
    if (ack_cnt[d] != low) begin
      bad++;
      $display("FAIL %s ack_len: can_tx low %0d cycles, expected %0d", name, ack_cnt[d], low);
    end
    ack_lo[d] = -1;
    ack_hi[d] = -1;
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      bad++;
      $display("FAIL %s drained: %0d/%0d events outstanding, expected 0/0", name, sb0.size(), sb1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({can_tx[d], rx_valid[d], crc_err[d], form_err[d]} !== 4'b1000) begin
        bad++;
        $display("FAIL reset_ctrl dut%0d: tx/valid/crc/form=%b%b%b%b, expected 1000",
                 d, can_tx[d], rx_valid[d], crc_err[d], form_err[d]);
      end
      total++;
      if ({rx_id[d], rx_rtr[d], rx_ide[d], rx_dlc[d], rx_data[d]} !== 23'd0) begin
        bad++;
        $display("FAIL reset_fields dut%0d: dlc=%h data=%h, expected all zero", d, rx_dlc[d], rx_data[d]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  task automatic test_good_frame();
    send_frame(0, mk_frame(1'b0, 1'b0, 1'b0, 4'd2, 16'h0001, 15'h4599, 1'b1, 3'b111), "good");
    check_drained("good");
    total++;
    if (rx_data[0] !== 16'h0001 || rx_dlc[0] !== 4'd2) begin
      bad++;
      $display("FAIL good_hold: data=%h dlc=%h, expected 0001 2", rx_data[0], rx_dlc[0]);
    end
  endtask

  task automatic test_crc_error();
    send_frame(0, mk_frame(1'b0, 1'b0, 1'b0, 4'd2, 16'h0001, 15'h4598, 1'b1, 3'b111), "crc_err");
    check_drained("crc_err");
    total++;
    if (rx_data[0] !== 16'h0001) begin
      bad++;
      $display("FAIL crc_keep: data=%h, expected 0001", rx_data[0]);
    end
  endtask

  task automatic test_form_error();
    send_frame(0, mk_frame(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 15'h0000, 1'b0, 3'b111), "form_err");
    check_drained("form_err");
    total++;
    if (rx_data[0] !== 16'h0001 || rx_dlc[0] !== 4'd2) begin
      bad++;
      $display("FAIL form_keep: data=%h dlc=%h, expected 0001 2", rx_data[0], rx_dlc[0]);
    end
    send_frame(0, mk_frame(1'b1, 1'b1, 1'b1, 4'hf, 16'ha5c3, crc15(16'ha5c3), 1'b1, 3'b111), "after_form");
    check_drained("after_form");
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk);
    #1;
    drive_bits(0, mk_frame(1'b0, 1'b1, 1'b0, 4'd7, 16'h5a5a, crc15(16'h5a5a), 1'b1, 3'b111), 16);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if ({can_tx[0], rx_valid[0], crc_err[0], form_err[0]} !== 4'b1000) begin
      bad++;
      $display("FAIL midreset_ctrl: tx/valid/crc/form=%b%b%b%b, expected 1000",
               can_tx[0], rx_valid[0], crc_err[0], form_err[0]);
    end
    total++;
    if ({rx_id[0], rx_rtr[0], rx_ide[0], rx_dlc[0], rx_data[0]} !== 23'd0) begin
      bad++;
      $display("FAIL midreset_fields: dlc=%h data=%h, expected all zero", rx_dlc[0], rx_data[0]);
    end
    can_rx[0] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (48) @(posedge clk);
    send_frame(0, mk_frame(1'b0, 1'b0, 1'b0, 4'd2, 16'h0001, 15'h4599, 1'b1, 3'b111), "post_reset");
    check_drained("post_reset");
  endtask

  task automatic test_back_to_back();
    send_frame(0, mk_frame(1'b1, 1'b0, 1'b1, 4'd3, 16'h1234, crc15(16'h1234), 1'b1, 3'b000), "b2b_a");
    repeat (15) @(posedge clk);
    send_frame(0, mk_frame(1'b0, 1'b1, 1'b0, 4'd8, 16'hffff, crc15(16'hffff), 1'b1, 3'b000), "b2b_b");
    repeat (64) @(posedge clk);
    check_drained("b2b");
    total++;
    if (rx_data[0] !== 16'hffff || rx_dlc[0] !== 4'd8) begin
      bad++;
      $display("FAIL b2b_hold: data=%h dlc=%h, expected ffff 8", rx_data[0], rx_dlc[0]);
    end
  endtask

  task automatic test_glitch();
    @(posedge clk);
    #1;
    can_rx[0] = 1'b0;
    can_rx[1] = 1'b0;
    @(posedge clk);
    #1;
    can_rx[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    can_rx[0] = 1'b1;
    repeat (80) @(posedge clk);
    check_drained("glitch");
    total++;
    if (rx_data[0] !== 16'hffff || rx_data[1] !== 16'h0000) begin
      bad++;
      $display("FAIL glitch_hold: data=%h/%h, expected ffff/0000", rx_data[0], rx_data[1]);
    end
    send_frame(0, mk_frame(1'b1, 1'b0, 1'b0, 4'd1, 16'h8000, crc15(16'h8000), 1'b1, 3'b111), "post_glitch");
    check_drained("post_glitch");
  endtask

  task automatic test_bit_ticks4();
    send_frame(1, mk_frame(1'b0, 1'b0, 1'b0, 4'd2, 16'h0001, 15'h4599, 1'b1, 3'b111), "bt4_good");
    repeat (8) @(posedge clk);
    check_drained("bt4_good");
    total++;
    if (rx_data[1] !== 16'h0001 || rx_dlc[1] !== 4'd2) begin
      bad++;
      $display("FAIL bt4_hold: data=%h dlc=%h, expected 0001 2", rx_data[1], rx_dlc[1]);
    end
  endtask

  initial begin
    rst        = 1'b1;
    can_rx[0]  = 1'b1;
    can_rx[1]  = 1'b1;
    ack_lo[0]  = -1;
    ack_lo[1]  = -1;
    ack_hi[0]  = -1;
    ack_hi[1]  = -1;
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    #2;
    test_reset();
    test_good_frame();
    test_crc_error();
    test_form_error();
    test_reset_mid_frame();
    test_back_to_back();
    test_glitch();
    test_bit_ticks4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
